// File: rtl/byte_word_bridge.sv
// byte_word_bridge: packs a byte stream into memory words (load) and streams stored words back out as bytes (dump).
// Define BWB_CHECKSUM_EN to add a running XOR checksum of the session's bytes.
module byte_word_bridge #(
    parameter int ADDR_WIDTH     = 12,
    parameter int BYTES_PER_WORD = 4,
    parameter bit BIG_ENDIAN     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        prog_en,
    input  logic                        read_en,
    input  logic [ADDR_WIDTH-1:0]       start_addr,
    input  logic [ADDR_WIDTH:0]         read_len,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [7:0]                  out_data,
    input  logic                        out_ready,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [8*BYTES_PER_WORD-1:0] mem_wdata,
    input  logic [8*BYTES_PER_WORD-1:0] mem_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic                        busy,
    output logic                        wr_done,
    output logic                        rd_done
`ifdef BWB_CHECKSUM_EN
    ,
    output logic [7:0]                  checksum
`endif
);
    localparam int W  = 8 * BYTES_PER_WORD;
    localparam int IW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {IDLE, PACK, WRITE, FETCH, LOAD, UNPACK} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [IW-1:0]         r_idx;
    logic [W-1:0]          r_shift;
    logic                  r_wr_done, r_rd_done;
    logic                  w_in_hs, w_out_hs, w_last, w_start, w_wr_done, w_rd_done;
    logic [IW-1:0]         w_lane;

    assign w_in_hs  = r_state == PACK && in_valid;
    assign w_out_hs = r_state == UNPACK && out_ready;
    assign w_last   = r_idx == LAST;
    assign w_lane   = BIG_ENDIAN ? LAST - r_idx : r_idx;
    assign w_start  = r_state == IDLE && (prog_en || read_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_wr_done = 1'b0;
        w_rd_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (prog_en) w_next = PACK;
                else if (read_en) begin
                    if (read_len == '0) w_rd_done = 1'b1;
                    else                w_next    = FETCH;
                end
            end
            PACK: begin
                // a byte arriving in the same cycle prog_en drops still makes the partial word
                if (w_in_hs && w_last) w_next = WRITE;
                else if (!prog_en) begin
                    if (r_idx != '0 || w_in_hs) w_next = WRITE;
                    else begin
                        w_next    = IDLE;
                        w_wr_done = 1'b1;
                    end
                end
            end
            WRITE: begin
                w_next    = prog_en ? PACK : IDLE;
                w_wr_done = !prog_en;
            end
            FETCH:   w_next = LOAD;
            LOAD:    w_next = UNPACK;
            UNPACK: begin
                if (w_out_hs && w_last) begin
                    w_next    = r_cnt != '0 ? FETCH : IDLE;
                    w_rd_done = r_cnt == '0;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = r_state != IDLE;
        in_ready  = r_state == PACK;
        out_valid = r_state == UNPACK;
        mem_en    = r_state == WRITE || r_state == FETCH;
        mem_we    = r_state == WRITE;
        out_data  = r_shift[8*w_lane +: 8];
        mem_addr  = r_addr;
        mem_wdata = r_shift;
        wr_done   = r_wr_done;
        rd_done   = r_rd_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_wr_done <= w_wr_done;
            r_rd_done <= w_rd_done;
            if (w_start) begin
                r_addr  <= start_addr;
                r_cnt   <= read_len;
                r_idx   <= '0;
                r_shift <= '0;
            end
            if (w_in_hs) begin
                r_shift[8*w_lane +: 8] <= in_data;
                r_idx                  <= r_idx + 1'b1;
            end
            // the shift word is cleared after each write so unfilled lanes of a flushed word read as 0
            if (r_state == WRITE) begin
                r_addr  <= r_addr + 1'b1;
                r_idx   <= '0;
                r_shift <= '0;
            end
            if (r_state == LOAD) begin
                r_shift <= mem_rdata;
                r_addr  <= r_addr + 1'b1;
                r_cnt   <= r_cnt - 1'b1;
                r_idx   <= '0;
            end
            if (w_out_hs) r_idx <= r_idx + 1'b1;
        end
    end

`ifdef BWB_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_csum <= '0;
        else if (w_start)  r_csum <= '0;
        else if (w_in_hs)  r_csum <= r_csum ^ in_data;
        else if (w_out_hs) r_csum <= r_csum ^ out_data;
    end

    assign checksum = r_csum;
`endif
endmodule

// File: tb/tb_byte_word_bridge.sv
// tb_byte_word_bridge: directed checks of load, partial flush, byte order, wrapped dump with stall, and edge cases.
module tb_byte_word_bridge;
    logic        clk = 0, rst = 1;
    logic        prog_en = 0, read_en = 0, in_valid = 0, out_ready = 0;
    logic [11:0] start_addr = '0;
    logic [12:0] read_len = '0;
    logic [7:0]  in_data = '0;
    logic [31:0] mem_rdata = '0;
    logic        in_ready, out_valid, mem_en, mem_we, busy, wr_done, rd_done;
    logic [7:0]  out_data;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        b_in_ready, b_out_valid, b_mem_en, b_mem_we, b_busy, b_wr_done, b_rd_done;
    logic [7:0]  b_out_data;
    logic [11:0] b_mem_addr;
    logic [31:0] b_mem_wdata, b_last = '0;
`ifdef BWB_CHECKSUM_EN
    logic [7:0]  checksum, b_checksum;
`endif
    logic [31:0] mem [0:4095];
    logic [11:0] wa[$], fa[$];
    logic [31:0] wd[$];
    int          n_chk = 0, n_pass = 0, wr_pulses = 0, en_cnt = 0;
    int          n, nw;
    logic [7:0]  dump_exp [0:7] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
    logic [7:0]  load_bytes [0:7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    always #5 clk = ~clk;

    byte_word_bridge #(.ADDR_WIDTH(12), .BYTES_PER_WORD(4), .BIG_ENDIAN(0)) dut (
        .clk(clk), .rst(rst), .prog_en(prog_en), .read_en(read_en), .start_addr(start_addr),
        .read_len(read_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .busy(busy), .wr_done(wr_done), .rd_done(rd_done)
`ifdef BWB_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    byte_word_bridge #(.ADDR_WIDTH(12), .BYTES_PER_WORD(4), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst(rst), .prog_en(prog_en), .read_en(read_en), .start_addr(start_addr),
        .read_len(read_len), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .busy(b_busy), .wr_done(b_wr_done), .rd_done(b_rd_done)
`ifdef BWB_CHECKSUM_EN
        , .checksum(b_checksum)
`endif
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
            end else begin
                mem_rdata <= mem[mem_addr];
                fa.push_back(mem_addr);
            end
            en_cnt++;
        end
        if (wr_done) wr_pulses++;
        if (b_mem_en && b_mem_we) b_last <= b_mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {busy, in_ready, out_valid, out_data, mem_en, mem_we, mem_addr, mem_wdata, wr_done, rd_done}, 64'd0);
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1;
        in_data  = b;
        for (int k = 0; k < 10 && !in_ready; k++) @(negedge clk);
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic recv(input logic [7:0] e);
        out_ready = 1;
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        chk("dump_byte", {out_valid, out_data}, {1'b1, e});
        @(negedge clk);
        out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        mem[12'hFFF] = 32'hDEADBEEF;
        mem[12'h000] = 32'h01020304;
        repeat (2) @(negedge clk);
        check_zero("reset_outputs");
        rst = 0;
        @(negedge clk);

        start_addr = 12'h010;
        prog_en    = 1;
        @(negedge clk);
        chk("load_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            send(load_bytes[i]);
            if (i == 3) chk("ready_gap", in_ready, 0);
        end
        prog_en = 0;
        n = wr_pulses;
        @(negedge clk);
        chk("load_done", {wr_done, busy}, 2'b10);
        @(negedge clk);
        chk("load_done_once", {wr_pulses - n, wr_done}, {32'd1, 1'b0});
        chk("load_nwrites", wa.size(), 2);
        chk("load_w0", {wa[0], wd[0]}, {12'h010, 32'h44332211});
        chk("load_w1", {wa[1], wd[1]}, {12'h011, 32'h88776655});

        start_addr = 12'h020;
        prog_en    = 1;
        @(negedge clk);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        prog_en = 0;
        @(negedge clk);
        chk("part_strobe", {mem_en, mem_we, mem_addr}, {2'b11, 12'h020});
        chk("part_data", mem_wdata, 32'h00CCBBAA);
        @(negedge clk);
        chk("part_done", wr_done, 1);

        start_addr = 12'h030;
        prog_en    = 1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(load_bytes[i]);
        prog_en = 0;
        @(negedge clk);
        chk("le_word", wd[wd.size()-1], 32'h44332211);
        chk("be_word", b_last, 32'h11223344);
`ifdef BWB_CHECKSUM_EN
        chk("checksum", checksum, 8'h44);
`endif

        start_addr = 12'hFFF;
        read_len   = 13'd2;
        read_en    = 1;
        @(negedge clk);
        read_en = 0;
        chk("dump_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_hold", {out_valid, out_data}, {1'b1, 8'hAD});
                end
            end
            recv(dump_exp[i]);
        end
        chk("dump_done", {rd_done, busy}, 2'b10);
        chk("fetch_addrs", {fa.size(), fa[0], fa[1]}, {32'd2, 12'hFFF, 12'h000});

        n          = en_cnt;
        read_len   = 13'd0;
        read_en    = 1;
        @(negedge clk);
        chk("zero_len_done", {rd_done, busy}, 2'b10);
        read_en = 0;
        @(negedge clk);
        chk("zero_len_no_mem", en_cnt - n, 0);

        prog_en = 1;
        read_en = 1;
        @(negedge clk);
        chk("both_load", {in_ready, out_valid}, 2'b10);
        prog_en = 0;
        read_en = 0;
        @(negedge clk);
        chk("both_done", {wr_done, rd_done}, 2'b10);

        nw         = wa.size();
        start_addr = 12'h040;
        prog_en    = 1;
        @(negedge clk);
        send(8'h5A);
        send(8'hA5);
        #2 rst = 1;
        #1 check_zero("async_reset");
        prog_en = 0;
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("async_no_write", wa.size(), nw);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/byte_word_bridge.md
# byte_word_bridge

Parametrised byte-stream to memory-word bridge that sits between the byte-wide program/debug link and a synchronous word memory bank. In load mode it packs incoming bytes into BYTES_PER_WORD-byte words and writes them to consecutive addresses. In dump mode it reads a given number of words and streams them out byte by byte. It is the generalised successor of the fixed 32-bit byte/word converter, adding valid/ready handshakes, selectable width and byte order, partial-word flush and bounded dumps.

## Interface
- ADDR_WIDTH, 12: memory word-address width.
- BYTES_PER_WORD, 4: bytes per memory word, 1..8. Word width W = 8*BYTES_PER_WORD.
- BIG_ENDIAN, 0: 0 = first byte in bits [7:0]; 1 = first byte in bits [W-1:W-8].
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- prog_en  in  1  level; start and hold load mode.
- read_en  in  1  level; start dump mode.
- start_addr  in  ADDR_WIDTH  first word address; sampled on session start.
- read_len  in  ADDR_WIDTH+1  words to dump; sampled on session start.
- in_valid / in_data[7:0] / in_ready  in/in/out  1/8/1  byte input handshake.
- out_valid / out_data[7:0] / out_ready  out/out/in  1/8/1  byte output handshake.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  W  write data.
- mem_rdata  in  W  read data; valid 1 cycle after a read strobe.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable; only high with mem_en.
- busy  out  1  high in any state other than IDLE.
- wr_done / rd_done  out  1  one-cycle pulses at load end / dump end.

## Operation
- States: IDLE, PACK, WRITE, FETCH, LOAD, UNPACK.
- IDLE: if prog_en, go to PACK. Else if read_en, go to FETCH, or stay in IDLE and pulse rd_done if read_len==0. The start latches addr<=start_addr, cnt<=read_len and clears byte_idx. prog_en has priority when both are high.
- PACK:
  - in_ready=1. Each accepted byte goes into lane byte_idx of the shift word (mirrored when BIG_ENDIAN) and byte_idx increments.
  - When the last lane is accepted, go to WRITE.
  - If prog_en falls with byte_idx>0, go to WRITE; unfilled lanes are written as 0.
  - If prog_en falls with byte_idx==0, go to IDLE and pulse wr_done.
- WRITE:
  - mem_en=mem_we=1 for one cycle; addr increments after the write and byte_idx clears.
  - Next state is PACK if prog_en is still high. Otherwise go to IDLE and pulse wr_done.
- FETCH: mem_en=1, mem_we=0 for one cycle, then go to LOAD.
- LOAD: capture mem_rdata into the shift word, increment addr, decrement cnt, clear byte_idx, go to UNPACK.
- UNPACK:
  - out_valid=1 and out_data = current lane. Each out_ready handshake advances byte_idx.
  - After the last lane: go to FETCH if cnt>0. Otherwise go to IDLE and pulse rd_done.
  - out_data holds stable while out_valid && !out_ready.
- Address wraps from 2^ADDR_WIDTH-1 to 0 silently.
- read_en falling mid-dump is ignored; the dump runs to read_len.
- An async reset mid-operation drops any partial word; nothing is written.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: in_ready, out_valid, out_data, mem_*, busy, wr_done, rd_done, plus checksum when present.
- in_ready is a registered function of state. It is 0 in WRITE, so a full word costs BYTES_PER_WORD+1 cycles at full rate.
- Dump cost is 2 cycles of overhead per word (FETCH, LOAD) plus BYTES_PER_WORD handshakes.
- mem_addr and mem_wdata are stable during the mem_en cycle.
- wr_done and rd_done are asserted in the cycle the FSM enters IDLE.
- busy falls in that same cycle.

## Configuration
- BWB_CHECKSUM_EN:
  - When defined, adds output checksum[7:0]: the XOR of every byte accepted (load) or handed off (dump) in the current session. It is cleared on session start and held after done.
  - When undefined, the port and its logic are absent and there is no other behaviour change.

## Test plan
- Load with BYTES_PER_WORD=4, BIG_ENDIAN=0, start_addr=0x010: send bytes 11,22,33,44,55,66,77,88 continuously, then drop prog_en.
  - Required: writes 0x44332211@0x010 and 0x88776655@0x011.
  - in_ready low one cycle after each fourth byte; wr_done 1 pulse.
- Partial flush: load 3 bytes AA,BB,CC, then drop prog_en. Required: write 0x00CCBBAA, then wr_done.
- BIG_ENDIAN=1 load of 11,22,33,44. Required: write 0x11223344.
- Dump:
  - Setup: read_len=2, start_addr=0xFFF, memory [0xFFF]=0xDEADBEEF, [0x000]=0x01020304.
  - Required: bytes EF,BE,AD,DE,04,03,02,01; address wraps to 0; rd_done after the last byte.
  - Hold out_ready low 5 cycles mid-stream; out_data must stay stable.
- Edge cases:
  - read_en with read_len=0 gives rd_done the next cycle with no mem_en.
  - prog_en and read_en high together starts load mode.
  - Async rst mid-PACK returns all outputs to 0 and produces no write.
- With BWB_CHECKSUM_EN defined, loading 11,22,33,44 gives checksum = 0x44.
